// File: rtl/dbus_req_ctrl.sv
// dbus_req_ctrl: data-bus request controller for the memory stage.
// Accepts one load/store per instruction, registers and holds the bus request
// until dreq_valid & dresp_addr_ok & dresp_data_ok, then returns aligned and
// extended load data. Misaligned or illegal-size accesses are reported with a
// one-cycle misalign pulse and never reach the bus. A flush while the access
// is outstanding drains it silently.
//
// Ports:
//   clk, reset (async, active-low)
//   req_*     : load/store decode from the memory stage
//   flush     : squash the current instruction
//   dreq_*    : registered bus request, held stable while outstanding
//   dresp_*   : bus handshake and raw load doubleword
//   resp_*    : one-cycle completion pulse with extended load data
//   misalign  : one-cycle pulse for rejected accesses
//   stall     : hold the memory stage and upstream
module dbus_req_ctrl #(
    parameter int XLEN   = 64,
    parameter int STRB_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [2:0]        req_size,
    input  logic              req_zeroext,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [XLEN-1:0]   dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [STRB_W-1:0] dreq_strobe,
    output logic [XLEN-1:0]   dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [XLEN-1:0]   dresp_data,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              misalign,
    output logic              stall
);

    localparam int OFF_W = $clog2(STRB_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [XLEN-1:0]   addr_q;
    logic [2:0]        size_q;
    logic              zx_q;
    logic              wr_q;
    logic [STRB_W-1:0] strb_q;
    logic [XLEN-1:0]   wdat_q;
    logic [XLEN-1:0]   rdata_q;
    logic              issued_q;   // DONE reached through a bus access (else misaligned)

    logic [OFF_W-1:0]  req_off;
    logic              req_misal;
    logic              accept;
    logic              outstanding;
    logic              hs;

    function automatic logic is_misaligned(input logic [2:0] size, input logic [OFF_W-1:0] off);
        case (size)
            3'd0:    is_misaligned = 1'b0;
            3'd1:    is_misaligned = off[0];
            3'd2:    is_misaligned = |off[1:0];
            3'd3:    is_misaligned = |off;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [STRB_W-1:0] make_strobe(input logic [2:0] size, input logic [OFF_W-1:0] off);
        logic [STRB_W-1:0] base;
        case (size)
            3'd0:    base = STRB_W'(8'h01);
            3'd1:    base = STRB_W'(8'h03);
            3'd2:    base = STRB_W'(8'h0F);
            default: base = STRB_W'(8'hFF);
        endcase
        make_strobe = base << off;
    endfunction

    // Bring the addressed lane down to bit 0, keep the access width, extend.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                    input logic [2:0] size,
                                                    input logic [OFF_W-1:0] off,
                                                    input logic zx);
        logic [XLEN-1:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            3'd0:    extend_load = {{(XLEN-8){~zx & sh[7]}},   sh[7:0]};
            3'd1:    extend_load = {{(XLEN-16){~zx & sh[15]}}, sh[15:0]};
            3'd2:    extend_load = {{(XLEN-32){~zx & sh[31]}}, sh[31:0]};
            default: extend_load = sh;
        endcase
    endfunction

    assign req_off     = req_addr[OFF_W-1:0];
    assign req_misal   = is_misaligned(req_size, req_off);
    assign accept      = (state == S_IDLE) && req_valid && !flush;
    assign outstanding = (state == S_REQ) || (state == S_DRAIN);
    assign hs          = outstanding && dresp_addr_ok && dresp_data_ok;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = req_misal ? S_DONE : S_REQ;
            S_REQ: begin
                // A flush coinciding with the handshake has nothing left to drain.
                if (hs)         state_nxt = flush ? S_IDLE : S_DONE;
                else if (flush) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (hs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            zx_q     <= 1'b0;
            wr_q     <= 1'b0;
            strb_q   <= '0;
            wdat_q   <= '0;
            rdata_q  <= '0;
            issued_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                issued_q <= !req_misal;
                if (!req_misal) begin
                    addr_q <= req_addr;
                    size_q <= req_size;
                    zx_q   <= req_zeroext;
                    wr_q   <= req_write;
                    strb_q <= req_write ? make_strobe(req_size, req_off) : '0;
                    wdat_q <= req_wdata << {req_off, 3'b000};
                end
            end
            if ((state == S_REQ) && hs)
                rdata_q <= wr_q ? '0 : extend_load(dresp_data, size_q, addr_q[OFF_W-1:0], zx_q);
        end
    end

    assign dreq_valid  = outstanding;
    assign dreq_addr   = addr_q;
    assign dreq_size   = size_q;
    assign dreq_strobe = strb_q;
    assign dreq_data   = wdat_q;

    assign resp_valid  = (state == S_DONE) && issued_q && !flush;
    assign resp_rdata  = resp_valid ? rdata_q : '0;
    assign misalign    = (state == S_DONE) && !issued_q && !flush;

    // Gated by reset so every output reads 0 while reset is held.
    assign stall       = reset && (outstanding || accept);

endmodule

// File: tb/tb_dbus_req_ctrl.sv
module tb_dbus_req_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_write, req_zeroext, flush;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        dreq_valid;
    logic [63:0] dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        resp_valid, misalign, stall;
    logic [63:0] resp_rdata;

    int checks = 0;
    int passes = 0;

    dbus_req_ctrl #(.XLEN(64), .STRB_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_size(req_size), .req_zeroext(req_zeroext), .req_wdata(req_wdata),
        .flush(flush),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .misalign(misalign), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // busy   : a bus access is outstanding
    // keep   : its result is still wanted (cleared by a flush)
    // report : pulse owed next cycle: 0 none, 1 completion, 2 misalign
    bit          m_busy, m_keep, m_wr, m_zx;
    logic [63:0] m_addr, m_data, m_rdata;
    logic [2:0]  m_size;
    logic [7:0]  m_strb;
    int          m_report;

    function automatic bit model_misal(input logic [63:0] a, input logic [2:0] s);
        if (s > 3) return 1'b1;
        return (a % (64'd1 << s)) != 0;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] raw, input logic [63:0] a,
                                               input logic [2:0] s, input bit zx);
        int nb;
        int off;
        logic [63:0] v, mask;
        nb   = 1 << s;
        off  = int'(a % 8);
        v    = raw >> (off * 8);
        mask = (nb == 8) ? {64{1'b1}} : ((64'd1 << (nb * 8)) - 64'd1);
        v    = v & mask;
        if (!zx && v[nb*8-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic model_clear();
        m_busy = 0; m_keep = 0; m_report = 0; m_rdata = '0;
    endtask

    initial begin
        bit exp_resp;
        model_clear();
        forever begin
            @(negedge clk);
            if (!reset) begin
                model_clear();
                chk("rst_dreq_valid", dreq_valid, 0);
                chk("rst_stall", stall, 0);
                chk("rst_resp_valid", resp_valid, 0);
                chk("rst_misalign", misalign, 0);
                chk("rst_resp_rdata", resp_rdata, 0);
                chk("rst_dreq_addr", dreq_addr, 0);
                chk("rst_dreq_strobe", dreq_strobe, 0);
                chk("rst_dreq_data", dreq_data, 0);
            end else begin
                chk("m_dreq_valid", dreq_valid, m_busy);
                if (m_busy) begin
                    chk("m_dreq_addr", dreq_addr, m_addr);
                    chk("m_dreq_size", dreq_size, m_size);
                    chk("m_dreq_strobe", dreq_strobe, m_strb);
                    chk("m_dreq_data", dreq_data, m_data);
                end
                exp_resp = (m_report == 1) && !flush;
                chk("m_resp_valid", resp_valid, exp_resp);
                chk("m_misalign", misalign, (m_report == 2) && !flush);
                if (exp_resp) chk("m_resp_rdata", resp_rdata, m_rdata);
                chk("m_stall", stall, m_busy || (m_report == 0 && req_valid && !flush));
            end
            @(posedge clk);
            if (reset) begin
                if (m_report != 0) begin
                    m_report = 0;
                end else if (m_busy) begin
                    if (flush) m_keep = 0;
                    if (dresp_addr_ok && dresp_data_ok) begin
                        m_busy = 0;
                        if (m_keep) begin
                            m_report = 1;
                            m_rdata  = m_wr ? 64'd0 : model_load(dresp_data, m_addr, m_size, m_zx);
                        end
                    end
                end else if (req_valid && !flush) begin
                    if (model_misal(req_addr, req_size)) begin
                        m_report = 2;
                    end else begin
                        m_busy = 1; m_keep = 1;
                        m_addr = req_addr; m_size = req_size;
                        m_wr = req_write; m_zx = req_zeroext;
                        m_strb = req_write ? 8'(((16'd1 << (1 << req_size)) - 16'd1) << (req_addr % 8)) : 8'h00;
                        m_data = req_wdata << ((req_addr % 8) * 8);
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic look();
        #1;
    endtask

    task automatic clr();
        req_valid = 0; req_write = 0; req_addr = '0; req_size = '0;
        req_zeroext = 0; req_wdata = '0; flush = 0;
        dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = '0;
    endtask

    task automatic set_req(input bit w, input logic [63:0] a, input logic [2:0] s,
                           input bit zx, input logic [63:0] wd);
        req_valid = 1; req_write = w; req_addr = a; req_size = s;
        req_zeroext = zx; req_wdata = wd;
    endtask

    task automatic set_hs(input logic [63:0] d);
        dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = d;
    endtask

    initial begin
        logic [7:0] lane;
        clr();
        reset = 0;
        cyc();
        req_valid = 1;
        look();
        chk("reset_stall_gated", stall, 0);
        clr();
        cyc();
        reset = 1;
        cyc();

        // Byte store at offset 5, handshake after three wait cycles.
        set_req(1, 64'h0000_0000_8000_0005, 3'd0, 0, 64'hAB);
        look();
        chk("t1_accept_stall", stall, 1);
        cyc(); clr();
        for (int i = 0; i < 3; i++) begin
            look();
            chk("t1_wait_stall", stall, 1);
            chk("t1_wait_dreq_valid", dreq_valid, 1);
            cyc();
        end
        set_hs(64'h0);
        look();
        lane = dreq_data[47:40];
        chk("t1_strobe", dreq_strobe, 8'h20);
        chk("t1_lane", lane, 8'hAB);
        chk("t1_hs_stall", stall, 1);
        cyc(); clr();
        look();
        chk("t1_resp_valid", resp_valid, 1);
        chk("t1_done_stall", stall, 0);
        chk("t1_store_rdata", resp_rdata, 0);
        cyc();
        look();
        chk("t1_resp_single", resp_valid, 0);

        // Halfword load at offset 6, sign- then zero-extended, minimum latency.
        set_req(0, 64'h0000_0000_0000_1006, 3'd1, 0, 64'h0);
        cyc(); clr();
        set_hs(64'h8001_0000_0000_0000);
        cyc(); clr();
        look();
        chk("t2_sext_valid", resp_valid, 1);
        chk("t2_sext_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_8001);
        cyc();
        set_req(0, 64'h0000_0000_0000_1006, 3'd1, 1, 64'h0);
        cyc(); clr();
        set_hs(64'h8001_0000_0000_0000);
        cyc(); clr();
        look();
        chk("t2_zext_rdata", resp_rdata, 64'h0000_0000_0000_8001);
        cyc();

        // Misaligned word load, illegal size, and a flush in DONE.
        set_req(0, 64'h0000_0000_0000_2002, 3'd2, 0, 64'h0);
        look();
        chk("t3_accept_stall", stall, 1);
        cyc(); clr();
        look();
        chk("t3_misalign", misalign, 1);
        chk("t3_no_dreq", dreq_valid, 0);
        chk("t3_no_resp", resp_valid, 0);
        chk("t3_done_stall", stall, 0);
        cyc();
        look();
        chk("t3_misalign_single", misalign, 0);
        set_req(0, 64'h0000_0000_0000_2000, 3'd5, 0, 64'h0);
        cyc(); clr();
        look();
        chk("t3_illegal_size", misalign, 1);
        cyc();
        set_req(1, 64'h0000_0000_0000_2001, 3'd3, 0, 64'h0);
        cyc(); clr();
        flush = 1;
        look();
        chk("t3_flush_suppress", misalign, 0);
        cyc(); clr();

        // Doubleword load: addr_ok alone, data_ok alone, then both.
        set_req(0, 64'h0000_0000_0001_0000, 3'd3, 0, 64'h0);
        cyc(); clr();
        for (int i = 0; i < 2; i++) begin
            dresp_addr_ok = 1; dresp_data_ok = 0; dresp_data = 64'hDEAD_BEEF_0123_4567;
            look();
            chk("t4_addr_only_hold", dreq_valid, 1);
            cyc();
        end
        dresp_addr_ok = 0; dresp_data_ok = 1;
        cyc();
        set_hs(64'hDEAD_BEEF_0123_4567);
        cyc(); clr();
        look();
        chk("t4_resp_valid", resp_valid, 1);
        chk("t4_rdata", resp_rdata, 64'hDEAD_BEEF_0123_4567);
        cyc();

        // Flush in the first REQ cycle, handshake two cycles later.
        set_req(0, 64'h0000_0000_0000_3040, 3'd2, 1, 64'h0);
        cyc(); clr();
        flush = 1;
        look();
        chk("t5_flush_stall", stall, 1);
        cyc(); clr();
        look();
        chk("t5_drain_valid", dreq_valid, 1);
        chk("t5_drain_addr", dreq_addr, 64'h0000_0000_0000_3040);
        cyc();
        set_hs(64'h1234_5678_9ABC_DEF0);
        flush = 1;
        cyc(); clr();
        look();
        chk("t5_no_resp", resp_valid, 0);
        chk("t5_idle_dreq", dreq_valid, 0);
        chk("t5_idle_stall", stall, 0);
        cyc();

        // Flush and handshake in the same REQ cycle.
        set_req(1, 64'h0000_0000_0000_3008, 3'd3, 0, 64'h1122_3344_5566_7788);
        cyc(); clr();
        flush = 1;
        set_hs(64'h0);
        cyc(); clr();
        look();
        chk("t5b_no_resp", resp_valid, 0);
        chk("t5b_idle", dreq_valid, 0);
        cyc();

        // Request held through DONE is taken as the next instruction.
        set_req(0, 64'h0000_0000_0000_4010, 3'd2, 0, 64'h0);
        cyc();
        set_hs(64'h0000_0000_F000_0001);
        cyc();
        dresp_addr_ok = 0; dresp_data_ok = 0;
        look();
        chk("t6_done_stall", stall, 0);
        chk("t6_resp", resp_rdata, 64'hFFFF_FFFF_F000_0001);
        cyc();
        look();
        chk("t6_reaccept_stall", stall, 1);
        chk("t6_idle_gap", dreq_valid, 0);
        cyc(); clr();
        look();
        chk("t6_second_issue", dreq_valid, 1);
        set_hs(64'h0000_0000_0000_0042);
        cyc(); clr();
        cyc();

        // Asynchronous reset while a store is outstanding.
        set_req(1, 64'h0000_0000_0000_5020, 3'd3, 0, 64'hCAFE_F00D_0000_0001);
        cyc(); clr();
        look();
        chk("t7_pre_reset_valid", dreq_valid, 1);
        #1 reset = 0;
        #1;
        chk("t7_async_dreq", dreq_valid, 0);
        chk("t7_async_stall", stall, 0);
        chk("t7_async_resp", resp_valid, 0);
        cyc(); cyc();
        reset = 1;
        set_req(1, 64'h0000_0000_0000_6003, 3'd0, 0, 64'h5A);
        look();
        chk("t7_fresh_stall", stall, 1);
        cyc(); clr();
        look();
        chk("t7_fresh_valid", dreq_valid, 1);
        chk("t7_fresh_strobe", dreq_strobe, 8'h08);
        chk("t7_fresh_data", dreq_data, 64'h0000_0000_5A00_0000);
        set_hs(64'h0);
        cyc(); clr();
        look();
        chk("t7_fresh_resp", resp_valid, 1);
        cyc(); cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dbus_req_ctrl.md
Name: dbus_req_ctrl

Overview:
Data-bus request controller between the memory stage's load/store decode and the dbus. It accepts one load/store per instruction and registers the bus request. It holds the request stable until the bus handshake completes, then returns aligned, extended load data. It produces the memory-stage stall and flags misaligned accesses without issuing them. A flush arriving mid-transaction drains the outstanding bus access rather than abandoning it.

Parameters:
XLEN, 64, data/address width.
STRB_W, 8, byte-strobe width (XLEN/8).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
req_valid  in  1  load/store present in memory stage.
req_write  in  1  1 = store, 0 = load.
req_addr  in  64  physical byte address.
req_size  in  3  0=1B, 1=2B, 2=4B, 3=8B; other values are illegal.
req_zeroext  in  1  load result is zero-extended (else sign-extended).
req_wdata  in  64  store data, right-justified.
flush  in  1  squash current instruction.
dreq_valid  out  1  bus request valid.
dreq_addr  out  64  bus address.
dreq_size  out  3  bus size.
dreq_strobe  out  8  byte enables; 0 for loads.
dreq_data  out  64  store data shifted to byte lane.
dresp_addr_ok  in  1  bus address accepted.
dresp_data_ok  in  1  bus data returned/accepted.
dresp_data  in  64  raw load doubleword.
resp_valid  out  1  one-cycle access-complete pulse.
resp_rdata  out  64  extended load result (0 for stores).
misalign  out  1  one-cycle pulse: access misaligned or size illegal, not issued.
stall  out  1  hold memory stage and upstream.

Behaviour:
- Reset (reset=0, async) forces state IDLE. All outputs are 0 during reset.
- FSM states: IDLE, REQ, DRAIN, DONE.
- Alignment: with off = addr[2:0], the access is misaligned when size=1 and off[0]!=0, size=2 and off[1:0]!=0, or size=3 and off!=0. Sizes 4-7 are illegal and treated as misaligned.
- IDLE, req_valid=1, flush=0, aligned:
  - Register addr/size.
  - strobe = 0 for loads; otherwise (0x01/0x03/0x0F/0xFF) << off.
  - data = wdata << (off*8).
  - Go to REQ. dreq_valid=1 from the next cycle.
- IDLE, req_valid=1, misaligned, flush=0: go to DONE with misalign=1, resp_valid=0, no bus request.
- IDLE, flush=1: stay IDLE and ignore the request.
- REQ: dreq_* held stable. The handshake is the cycle where dreq_valid & dresp_addr_ok & dresp_data_ok are all 1.
  - On handshake, go to DONE and capture read data: rd = dresp_data >> (off*8), truncated to size, then sign- or zero-extended per the latched zeroext.
  - addr_ok alone, or data_ok alone, is not a handshake. Keep waiting.
- REQ with flush=1 and no handshake: go to DRAIN. dreq_* stays held.
- REQ with flush=1 and handshake in the same cycle: go to IDLE, no resp_valid.
- DRAIN: on handshake go to IDLE. Read data is discarded and resp_valid is not pulsed. flush is ignored.
- DONE: lasts exactly one cycle.
  - If the access was issued, resp_valid=1 and resp_rdata is valid.
  - If the access was misaligned, misalign=1.
  - dreq_valid=0. Next state is IDLE.
  - flush in DONE suppresses both pulses.
- stall is combinational:
  - 1 when state is REQ or DRAIN.
  - 1 in IDLE when req_valid=1, flush=0, and a new access is being accepted.
  - 0 in DONE, so the pipeline advances in the DONE cycle.
  - Upstream presents the next instruction on the following cycle.
- Minimum latency: accept at cycle N, dreq_valid at N+1, handshake at N+1, resp_valid at N+2.
- A request that is still valid on the cycle after DONE is treated as a new instruction.
- Back-to-back accesses: one idle cycle between DONE and the next dreq_valid.

Test Plan:
- Byte store, addr=0x..05, size=0, wdata=0xAB → strobe=0x20, dreq_data[47:40]=0xAB. Handshake after 3 wait cycles → resp_valid one cycle, stall high for 4 cycles after accept.
- Load halfword, addr=0x..06, dresp_data=0x8001_0000_0000_0000, zeroext=0 → resp_rdata=0xFFFF_FFFF_FFFF_8001. With zeroext=1 → resp_rdata=0x8001.
- Word load at addr=0x..02 → misalign=1 for one cycle, dreq_valid never asserted, resp_valid=0.
- Load at addr=0x..00, size=3. addr_ok=1 with data_ok=0 for 2 cycles → no completion. Both high → resp_valid next cycle, resp_rdata=dresp_data.
- Issued load, flush in first REQ cycle, handshake 2 cycles later → dreq held stable throughout, no resp_valid, state returns to IDLE.
- Reset asserted during REQ → dreq_valid, stall and resp_valid drop immediately (asynchronously). After release, IDLE accepts a fresh store normally.
